riscv_ex_stage: RTL
===================

// Module: riscv_ex_stage
// PURPOSE
//  Execute stage downstream of the fetch/decode stage. Consumes the registered id_* decode bundle plus
//  register-file read data. Computes ALU/MUL results, iterative DIV/REM, load/store addresses and
//  branch/jump resolution. Returns branch_taken_w/jump_addr_w/ex_stall_w to fetch/decode and
//  registers the writeback/memory request for the next stage.
// PARAMETERS
//  DIV_CYCLES  32  ex_stall_w high-cycles per DIV/REM (one quotient bit per cycle)
// PORTS
//  clk_i           in   1   clock
//  reset_ni        in   1   asynchronous active-low reset
//  id_pc_r         in  32   PC of instruction in execute
//  id_next_pc_r    in  32   PC+4, link value for jumps
//  id_rd_index_r   in   5   dest reg; 0 = no write (decode drives 0 for store/cond-branch)
//  rs1_data_i      in  32   register file data for addr_1
//  rs2_data_i      in  32   register file data for addr_2
//  id_a_signed_r   in   1   operand A signed (SLT/BLT/MULH/DIV/REM)
//  id_b_signed_r   in   1   operand B signed
//  id_alu_op_r     in   4   `ALU_* opcode
//  id_imm_r        in  32   immediate
//  id_op_imm_r     in   1   operand B = id_imm_r, else rs2_data_i
//  id_mem_rd_r     in   1   load
//  id_mem_wr_r     in   1   store
//  id_mem_signed_r in   1   load sign-extend
//  id_mem_size_r   in   2   0 byte, 1 half, 2 word
//  id_branch_r     in   3   0 none, 1 jump, 2 BEQ, 3 BNE, 4 BLT, 5 BGE
//  id_reg_jump_r   in   1   jump target base rs1 (JALR), else PC
//  branch_taken_w  out  1   registered redirect to fetch
//  jump_addr_w     out 32   registered redirect target, bits[1:0] = 0
//  ex_stall_w      out  1   divider busy; fetch/decode hold
//  ex_rd_index_r   out  5   writeback index
//  ex_rd_we_r      out  1   writeback enable
//  ex_rd_data_r    out 32   writeback data (ALU result or link)
//  ex_mem_rd_r     out  1   load request
//  ex_mem_wr_r     out  1   store request
//  ex_mem_signed_r out  1   load sign-extend
//  ex_mem_size_r   out  2   access size
//  ex_mem_addr_r   out 32   rs1 + imm
//  ex_mem_wdata_r  out 32   rs2_data_i
// BEHAVIOUR
//  - Reset: all outputs 0; divider IDLE, count 0.
//  - Latency: every registered output is valid the cycle after the instruction sits in id_*.
//  - Annul: while branch_taken_w==1, the current id_* instruction is dropped: no we, no mem, no
//    branch, no DIV start. Decode bubbles the following slot itself.
//  - ALU: ADD SUB AND OR XOR SLL SRL SRA SLT MUL MULH DIV REM. Shifts use B[4:0].
//    SLT signedness comes from id_a_signed_r. MULH uses 33x33 operands extended per a/b_signed.
//    All results are truncated to 32 bits.
//  - Branch: cond on rs1 vs rs2 (BLT/BGE signed iff id_a_signed_r). Target is (base+imm) with
//    bits[1:0] forced 0. Jump writes rd = id_next_pc_r and is always taken.
//  - Load: ex_rd_we_r = 0; ex_rd_index_r is forwarded for the memory stage. Store: ex_mem_wr_r = 1
//    and no write.
//  - Divider FSM IDLE->BUSY->IDLE.
//    - IDLE: when op is DIV/REM and not annulled, latch operands and go BUSY. ex_stall_w = 0 in this
//      accept cycle (decode self-holds on DIV). No writeback in the accept cycle.
//    - BUSY: ex_stall_w = 1 for exactly DIV_CYCLES cycles. In the following (done) cycle,
//      ex_stall_w = 0, the result registers with ex_rd_we_r = 1, and the FSM returns to IDLE.
//    - A back-to-back DIV presented after done is accepted immediately.
//    - Divide by 0: quotient = 32'hFFFF_FFFF, remainder = dividend.
//    - Signed -2^31 / -1: quotient = 32'h8000_0000, remainder = 0.
//    - Signed results are sign-corrected from magnitudes.
//  - While BUSY or in the accept cycle: no branch, no mem, no we; id_* inputs are ignored.
//  - Async reset mid-divide aborts to IDLE; ex_stall_w drops immediately.
// STRUCTURE
//  - Shared package riscv_pkg: `ALU_* codes, branch codes (BR_NONE..BR_BGE), mem size codes.
//  - Sub-module riscv_div_iter: restoring divider with start/busy/done handshake, signed flag,
//    and quotient/remainder outputs.
// TESTING
//  - ADD rs1=5, imm=-7, rd=3 -> next cycle ex_rd_we_r=1, ex_rd_data_r=32'hFFFF_FFFE.
//  - BEQ rs1=rs2=9, pc=0x100, imm=0x20 -> branch_taken_w=1, jump_addr_w=0x120.
//    The ADD held in id_* in that cycle produces no write.
//  - JALR rs1=0x203, imm=0, next_pc=0x48 -> jump_addr_w=0x200, ex_rd_data_r=0x48.
//  - DIV signed -7/2 -> ex_stall_w low 1 cycle, high 32 cycles, then quotient 32'hFFFF_FFFD.
//    REM gives 32'hFFFF_FFFF.
//  - DIVU 10/0 -> 32'hFFFF_FFFF. REM 10/0 -> 10. Two back-to-back DIVs give two full stall windows.
//  - Assert reset_ni=0 at cycle 10 of a divide -> ex_stall_w=0 at once; all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, branch codes,
// memory access sizes, divider state encoding and a small arithmetic helper.
package riscv_pkg;

    // ALU opcodes carried on id_alu_op_r
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_MULH = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_REM  = 4'd12;

    // Branch/jump kinds carried on id_branch_r
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_JUMP = 3'd1;
    localparam logic [2:0] BR_BEQ  = 3'd2;
    localparam logic [2:0] BR_BNE  = 3'd3;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;

    // Memory access sizes carried on id_mem_size_r
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    // Iterative divider sequencing
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set (magnitude <-> signed conversion)
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        if (neg) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/riscv_div_iter.sv
// Restoring divider, one quotient bit per cycle. Operands are converted to
// magnitudes on start and the signs are re-applied to the final results.
// A zero divisor yields all-ones quotient and the raw dividend as remainder.
module riscv_div_iter
    import riscv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_e        state_r;
    div_state_e        state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       quo_r;
    logic [31:0]       rem_r;
    logic [31:0]       divisor_r;
    logic [31:0]       dividend_r;
    logic              q_neg_r;
    logic              r_neg_r;
    logic              dbz_r;
    logic [32:0]       partial_s;
    logic [32:0]       diff_s;
    logic [31:0]       rem_step_s;
    logic [31:0]       quo_step_s;

    // State register; async reset aborts any divide in flight
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: accept on start, hold BUSY for DIV_CYCLES, one DONE cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start) begin
                    state_nxt_s = DIV_BUSY;
                end else begin
                    state_nxt_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (count_r == CNT_LAST) begin
                    state_nxt_s = DIV_DONE;
                end else begin
                    state_nxt_s = DIV_BUSY;
                end
            end
            DIV_DONE: state_nxt_s = DIV_IDLE;
            default:  state_nxt_s = DIV_IDLE;
        endcase
    end

    // Handshake outputs and sign-corrected results
    always_comb begin
        busy = (state_r == DIV_BUSY);
        done = (state_r == DIV_DONE);
        if (dbz_r) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dividend_r;
        end else begin
            quotient  = neg_if(quo_r, q_neg_r);
            remainder = neg_if(rem_r, r_neg_r);
        end
    end

    // One restoring step: shift in the next dividend bit and trial-subtract
    always_comb begin
        partial_s = {rem_r, quo_r[31]};
        diff_s    = partial_s - {1'b0, divisor_r};
        if (!diff_s[32]) begin
            rem_step_s = diff_s[31:0];
            quo_step_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_step_s = partial_s[31:0];
            quo_step_s = {quo_r[30:0], 1'b0};
        end
    end

    // Operand capture on start, iteration while busy
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_r    <= '0;
            quo_r      <= 32'd0;
            rem_r      <= 32'd0;
            divisor_r  <= 32'd0;
            dividend_r <= 32'd0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            dbz_r      <= 1'b0;
        end else if ((state_r == DIV_IDLE) && start) begin
            count_r    <= '0;
            quo_r      <= neg_if(dividend, signed_op & dividend[31]);
            rem_r      <= 32'd0;
            divisor_r  <= neg_if(divisor, signed_op & divisor[31]);
            dividend_r <= dividend;
            q_neg_r    <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg_r    <= signed_op & dividend[31];
            dbz_r      <= (divisor == 32'd0);
        end else if (state_r == DIV_BUSY) begin
            count_r <= count_r + CNT_W'(1);
            quo_r   <= quo_step_s;
            rem_r   <= rem_step_s;
        end
    end

endmodule

// File: rtl/riscv_ex_stage.sv
// Execute stage: ALU/MUL, iterative DIV/REM, load/store address generation
// and branch resolution. All results register one cycle after the
// instruction sits in id_*. A taken redirect annuls the following slot.
module riscv_ex_stage
    import riscv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] id_pc_r,
    input  logic [31:0] id_next_pc_r,
    input  logic [4:0]  id_rd_index_r,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        id_a_signed_r,
    input  logic        id_b_signed_r,
    input  logic [3:0]  id_alu_op_r,
    input  logic [31:0] id_imm_r,
    input  logic        id_op_imm_r,
    input  logic        id_mem_rd_r,
    input  logic        id_mem_wr_r,
    input  logic        id_mem_signed_r,
    input  logic [1:0]  id_mem_size_r,
    input  logic [2:0]  id_branch_r,
    input  logic        id_reg_jump_r,
    output logic        branch_taken_w,
    output logic [31:0] jump_addr_w,
    output logic        ex_stall_w,
    output logic [4:0]  ex_rd_index_r,
    output logic        ex_rd_we_r,
    output logic [31:0] ex_rd_data_r,
    output logic        ex_mem_rd_r,
    output logic        ex_mem_wr_r,
    output logic        ex_mem_signed_r,
    output logic [1:0]  ex_mem_size_r,
    output logic [31:0] ex_mem_addr_r,
    output logic [31:0] ex_mem_wdata_r
);

    logic [31:0] op_b_s;
    logic [32:0] a_ext_s;
    logic [32:0] b_ext_s;
    logic [63:0] prod_s;
    logic        alu_lt_s;
    logic [31:0] alu_res_s;
    logic        br_lt_s;
    logic        cond_s;
    logic [31:0] target_s;
    logic        is_div_s;
    logic        div_start_s;
    logic        div_busy_s;
    logic        div_done_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;
    logic [4:0]  div_rd_r;
    logic        div_is_rem_r;

    logic        nxt_taken_s;
    logic [31:0] nxt_jump_s;
    logic [4:0]  nxt_rd_index_s;
    logic        nxt_rd_we_s;
    logic [31:0] nxt_rd_data_s;
    logic        nxt_mem_rd_s;
    logic        nxt_mem_wr_s;
    logic        nxt_mem_signed_s;
    logic [1:0]  nxt_mem_size_s;
    logic [31:0] nxt_mem_addr_s;
    logic [31:0] nxt_mem_wdata_s;

    assign is_div_s    = (id_alu_op_r == ALU_DIV) || (id_alu_op_r == ALU_REM);
    assign div_start_s = is_div_s && !div_busy_s && !div_done_s && !branch_taken_w;
    assign ex_stall_w  = div_busy_s;

    riscv_div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .start     (div_start_s),
        .signed_op (id_a_signed_r),
        .dividend  (rs1_data_i),
        .divisor   (op_b_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // ALU: operand select, 33x33 multiply (low 64 bits suffice) and result mux
    always_comb begin
        op_b_s  = id_op_imm_r ? id_imm_r : rs2_data_i;
        a_ext_s = {id_a_signed_r & rs1_data_i[31], rs1_data_i};
        b_ext_s = {id_b_signed_r & op_b_s[31], op_b_s};
        prod_s  = {{31{a_ext_s[32]}}, a_ext_s} * {{31{b_ext_s[32]}}, b_ext_s};
        if (id_a_signed_r) begin
            alu_lt_s = $signed(rs1_data_i) < $signed(op_b_s);
        end else begin
            alu_lt_s = rs1_data_i < op_b_s;
        end
        case (id_alu_op_r)
            ALU_ADD:  alu_res_s = rs1_data_i + op_b_s;
            ALU_SUB:  alu_res_s = rs1_data_i - op_b_s;
            ALU_AND:  alu_res_s = rs1_data_i & op_b_s;
            ALU_OR:   alu_res_s = rs1_data_i | op_b_s;
            ALU_XOR:  alu_res_s = rs1_data_i ^ op_b_s;
            ALU_SLL:  alu_res_s = rs1_data_i << op_b_s[4:0];
            ALU_SRL:  alu_res_s = rs1_data_i >> op_b_s[4:0];
            ALU_SRA:  alu_res_s = 32'($signed(rs1_data_i) >>> op_b_s[4:0]);
            ALU_SLT:  alu_res_s = {31'd0, alu_lt_s};
            ALU_MUL:  alu_res_s = prod_s[31:0];
            ALU_MULH: alu_res_s = prod_s[63:32];
            default:  alu_res_s = 32'd0;
        endcase
    end

    // Branch condition on rs1 vs rs2 and word-aligned redirect target
    always_comb begin
        if (id_a_signed_r) begin
            br_lt_s = $signed(rs1_data_i) < $signed(rs2_data_i);
        end else begin
            br_lt_s = rs1_data_i < rs2_data_i;
        end
        case (id_branch_r)
            BR_JUMP: cond_s = 1'b1;
            BR_BEQ:  cond_s = (rs1_data_i == rs2_data_i);
            BR_BNE:  cond_s = (rs1_data_i != rs2_data_i);
            BR_BLT:  cond_s = br_lt_s;
            BR_BGE:  cond_s = !br_lt_s;
            default: cond_s = 1'b0;
        endcase
        target_s = ((id_reg_jump_r ? rs1_data_i : id_pc_r) + id_imm_r) & 32'hFFFF_FFFC;
    end

    // Next output bundle: divider result, bubble, or the current instruction
    always_comb begin
        nxt_taken_s      = 1'b0;
        nxt_jump_s       = 32'd0;
        nxt_rd_index_s   = 5'd0;
        nxt_rd_we_s      = 1'b0;
        nxt_rd_data_s    = 32'd0;
        nxt_mem_rd_s     = 1'b0;
        nxt_mem_wr_s     = 1'b0;
        nxt_mem_signed_s = 1'b0;
        nxt_mem_size_s   = 2'd0;
        nxt_mem_addr_s   = 32'd0;
        nxt_mem_wdata_s  = 32'd0;
        if (div_done_s) begin
            // id_* still holds the finishing DIV/REM; write its result back
            nxt_rd_index_s = div_rd_r;
            nxt_rd_we_s    = (div_rd_r != 5'd0);
            nxt_rd_data_s  = div_is_rem_r ? div_rem_s : div_quo_s;
        end else if (branch_taken_w || div_busy_s || is_div_s) begin
            // annulled slot, DIV accept cycle or divider busy: emit a bubble
            nxt_taken_s = 1'b0;
        end else begin
            nxt_taken_s      = cond_s;
            nxt_jump_s       = target_s;
            nxt_rd_index_s   = id_rd_index_r;
            nxt_rd_we_s      = (id_rd_index_r != 5'd0) && !id_mem_rd_r && !id_mem_wr_r;
            nxt_rd_data_s    = (id_branch_r == BR_JUMP) ? id_next_pc_r : alu_res_s;
            nxt_mem_rd_s     = id_mem_rd_r;
            nxt_mem_wr_s     = id_mem_wr_r;
            nxt_mem_signed_s = id_mem_signed_r;
            nxt_mem_size_s   = id_mem_size_r;
            nxt_mem_addr_s   = rs1_data_i + id_imm_r;
            nxt_mem_wdata_s  = rs2_data_i;
        end
    end

    // Destination and op kind of the DIV/REM in flight
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_rd_r     <= 5'd0;
            div_is_rem_r <= 1'b0;
        end else if (div_start_s) begin
            div_rd_r     <= id_rd_index_r;
            div_is_rem_r <= (id_alu_op_r == ALU_REM);
        end
    end

    // Registered writeback, memory request and redirect
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            branch_taken_w  <= 1'b0;
            jump_addr_w     <= 32'd0;
            ex_rd_index_r   <= 5'd0;
            ex_rd_we_r      <= 1'b0;
            ex_rd_data_r    <= 32'd0;
            ex_mem_rd_r     <= 1'b0;
            ex_mem_wr_r     <= 1'b0;
            ex_mem_signed_r <= 1'b0;
            ex_mem_size_r   <= 2'd0;
            ex_mem_addr_r   <= 32'd0;
            ex_mem_wdata_r  <= 32'd0;
        end else begin
            branch_taken_w  <= nxt_taken_s;
            jump_addr_w     <= nxt_jump_s;
            ex_rd_index_r   <= nxt_rd_index_s;
            ex_rd_we_r      <= nxt_rd_we_s;
            ex_rd_data_r    <= nxt_rd_data_s;
            ex_mem_rd_r     <= nxt_mem_rd_s;
            ex_mem_wr_r     <= nxt_mem_wr_s;
            ex_mem_signed_r <= nxt_mem_signed_s;
            ex_mem_size_r   <= nxt_mem_size_s;
            ex_mem_addr_r   <= nxt_mem_addr_s;
            ex_mem_wdata_r  <= nxt_mem_wdata_s;
        end
    end

endmodule
